// File: rtl/ctlr_pkg.sv
// Shared definitions for the NES joypad link: FSM states, button bit indices, frame length.
// Used by both the device-side responder and the CPU-side controller interface.
package ctlr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DRAIN = 2'd3
  } ctlr_state_t;

  localparam int CTLR_BITS = 8;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/ctlr_debounce.sv
// One-bit input synchronizer with optional debounce counter (DEBOUNCE_CYCLES=0 bypasses it).
// prev_o is the second-to-last sync stage, db_o the last stage (or its debounced value).
module ctlr_debounce #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RST_VAL         = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic prev_o,
  output logic db_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= {SYNC_STAGES{RST_VAL}};
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
  end

  assign prev_o = sync_q[SYNC_STAGES-2];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign db_o = sync_q[SYNC_STAGES-1];
    end else begin : g_deb
      localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
      localparam logic [CW-1:0] CNT_SAT  = CW'(DEBOUNCE_CYCLES);

      logic [CW-1:0] cnt_q, cnt_d;
      logic          db_q, db_d;

      // Count consecutive clocks where the synchronized input disagrees with the accepted state.
      always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        if (sync_q[SYNC_STAGES-1] == db_q) begin
          cnt_d = '0;
        end else begin
          if (cnt_q == CNT_LAST) db_d = sync_q[SYNC_STAGES-1];
          if (cnt_q != CNT_SAT)  cnt_d = cnt_q + CW'(1);
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          cnt_q <= '0;
          db_q  <= RST_VAL;
        end else begin
          cnt_q <= cnt_d;
          db_q  <= db_d;
        end
      end

      assign db_o = db_q;
    end
  endgenerate

endmodule

// File: rtl/ctlr_responder.sv
// Device end of one NES joypad link: debounced buttons captured on latch and shifted out
// one bit per pulse rise on an active-low serial line, like a 4021 shifter.
module ctlr_responder
  import ctlr_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] buttons,
  input  logic       ctlr_latch,
  input  logic       ctlr_pulse,
  output logic       ctlr_data,
  output logic [7:0] buttons_db,
  output logic [3:0] bit_count
);

  logic latch_new, latch_old, pulse_new, pulse_old;
  logic latch_rise, latch_fall, pulse_rise;
  logic [CTLR_BITS-1:0] unused_btn_prev;

  ctlr_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(0), .RST_VAL(1'b0)) u_latch_sync (
    .clk_i(clock), .rst_i(reset), .raw_i(ctlr_latch), .prev_o(latch_new), .db_o(latch_old)
  );

  ctlr_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(0), .RST_VAL(1'b1)) u_pulse_sync (
    .clk_i(clock), .rst_i(reset), .raw_i(ctlr_pulse), .prev_o(pulse_new), .db_o(pulse_old)
  );

  for (genvar i = 0; i < CTLR_BITS; i++) begin : g_btn
    ctlr_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b0)) u_btn (
      .clk_i(clock), .rst_i(reset), .raw_i(buttons[i]), .prev_o(unused_btn_prev[i]), .db_o(buttons_db[i])
    );
  end

  assign latch_rise = latch_new & ~latch_old;
  assign latch_fall = ~latch_new & latch_old;
  assign pulse_rise = pulse_new & ~pulse_old;

  ctlr_state_t          state_q, state_d;
  logic [CTLR_BITS-1:0] shreg_q, shreg_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 data_q, data_d;

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A latch rise reloads from any state, including mid-shift.
  always_comb begin
    state_d = state_q;
    if (latch_rise) begin
      state_d = LOAD;
    end else begin
      unique case (state_q)
        IDLE:    state_d = IDLE;
        LOAD:    if (latch_fall) state_d = SHIFT;
        SHIFT:   if (pulse_rise && cnt_q == 4'(CTLR_BITS - 1)) state_d = DRAIN;
        DRAIN:   state_d = DRAIN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Latch fall takes precedence over a coincident pulse rise because LOAD ignores pulses.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    data_d  = (state_q == IDLE) ? 1'b1 : ~shreg_q[0];
    if (latch_rise || (state_q == LOAD && latch_new)) begin
      shreg_d = buttons_db;
    end else if (state_q == LOAD && latch_fall) begin
      cnt_d = '0;
    end else if (state_q == SHIFT && pulse_rise) begin
      shreg_d = {1'b1, shreg_q[CTLR_BITS-1:1]};
      cnt_d   = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      data_q  <= 1'b1;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  assign ctlr_data = data_q;
  assign bit_count = cnt_q;

endmodule

// File: tb/tb_ctlr_responder.sv
// Directed bench for ctlr_responder with short debounce: table of button patterns plus
// hand-written sequences for glitch rejection, mid-shift reload, coincident edges and reset.
module tb_ctlr_responder;
  import ctlr_pkg::*;

  logic       clock;
  logic       reset;
  logic [7:0] buttons;
  logic       ctlr_latch;
  logic       ctlr_pulse;
  logic       ctlr_data;
  logic [7:0] buttons_db;
  logic [3:0] bit_count;

  int n_tests = 0;
  int n_fail  = 0;

  ctlr_responder #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .buttons(buttons), .ctlr_latch(ctlr_latch),
    .ctlr_pulse(ctlr_pulse), .ctlr_data(ctlr_data), .buttons_db(buttons_db), .bit_count(bit_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] btn;
    logic [9:0] reads;  // reads[i] = ctlr_data sampled before pulse rise i
  } vec_t;

  vec_t vecs[5];

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_latch();
    ctlr_latch = 1'b1;
    tick(6);
    ctlr_latch = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    ctlr_pulse = 1'b0;
    tick(6);
    b = ctlr_data;
    ctlr_pulse = 1'b1;
    tick(6);
  endtask

  logic b;

  initial begin
    vecs[0] = '{btn: 8'h09, reads: 10'b0011110110};
    vecs[1] = '{btn: 8'h00, reads: 10'b0011111111};
    vecs[2] = '{btn: 8'hFF, reads: 10'b0000000000};
    vecs[3] = '{btn: 8'hA5, reads: 10'b0001011010};
    vecs[4] = '{btn: 8'h80, reads: 10'b0001111111};

    reset = 1'b1; buttons = 8'h00; ctlr_latch = 1'b0; ctlr_pulse = 1'b1;
    tick(2);
    chk("rst_data", 32'(ctlr_data), 32'd1);
    chk("rst_count", 32'(bit_count), 32'd0);
    chk("rst_db", 32'(buttons_db), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    reset = 1'b0;
    tick(2);

    for (int k = 0; k < 2; k++) begin
      read_bit(b);
      chk("idle_data", 32'(b), 32'd1);
    end
    chk("idle_count", 32'(bit_count), 32'd0);
    chk("idle_state", 32'(dut.state_q), 32'(IDLE));

    for (int v = 0; v < 5; v++) begin
      buttons = vecs[v].btn;
      tick(12);
      chk($sformatf("v%0d_db", v), 32'(buttons_db), 32'(vecs[v].btn));
      do_latch();
      for (int i = 0; i < 10; i++) begin
        read_bit(b);
        chk($sformatf("v%0d_read%0d", v, i), 32'(b), 32'(vecs[v].reads[i]));
      end
      chk($sformatf("v%0d_count", v), 32'(bit_count), 32'd8);
      chk($sformatf("v%0d_state", v), 32'(dut.state_q), 32'(DRAIN));
    end

    // Three-clock glitch on B must not be accepted
    buttons = 8'h00;
    tick(12);
    buttons = 8'h02;
    tick(3);
    buttons = 8'h00;
    for (int k = 0; k < 6; k++) begin
      tick(1);
      chk("glitch_db", 32'(buttons_db), 32'd0);
    end
    do_latch();
    read_bit(b);
    chk("glitch_readA", 32'(b), 32'd1);
    read_bit(b);
    chk("glitch_readB", 32'(b), 32'd1);

    // Mid-shift reload
    buttons = 8'h01;
    tick(12);
    do_latch();
    for (int k = 0; k < 3; k++) read_bit(b);
    chk("reload_count3", 32'(bit_count), 32'd3);
    chk("reload_data_pre", 32'(ctlr_data), 32'd1);
    ctlr_latch = 1'b1;
    tick(3);
    chk("reload_state", 32'(dut.state_q), 32'(LOAD));
    chk("reload_data", 32'(ctlr_data), 32'd0);
    tick(3);
    ctlr_latch = 1'b0;
    tick(4);
    chk("reload_count0", 32'(bit_count), 32'd0);
    chk("reload_shift", 32'(dut.state_q), 32'(SHIFT));

    // Latch fall and pulse rise in the same clock
    ctlr_latch = 1'b1;
    ctlr_pulse = 1'b0;
    tick(6);
    ctlr_latch = 1'b0;
    ctlr_pulse = 1'b1;
    tick(6);
    chk("coinc_count", 32'(bit_count), 32'd0);
    chk("coinc_state", 32'(dut.state_q), 32'(SHIFT));
    chk("coinc_data", 32'(ctlr_data), 32'd0);
    read_bit(b);
    chk("coinc_count1", 32'(bit_count), 32'd1);
    chk("coinc_data1", 32'(ctlr_data), 32'd1);

    // Reset during SHIFT with five bits shifted
    buttons = 8'h20;
    tick(12);
    do_latch();
    for (int k = 0; k < 5; k++) read_bit(b);
    chk("mid_count5", 32'(bit_count), 32'd5);
    chk("mid_data", 32'(ctlr_data), 32'd0);
    reset = 1'b1;
    tick(1);
    chk("mid_rst_data", 32'(ctlr_data), 32'd1);
    chk("mid_rst_count", 32'(bit_count), 32'd0);
    chk("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
    reset = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
